// File: rtl/uart_dump_tx.sv
// uart_dump_tx: streams DUMP_WORDS words of instruction memory out over UART, LSB first, byte0 first.
// Optional UART_DUMP_PARITY_EN: adds an even parity bit after the data bits (8E1 instead of 8N1).
module uart_dump_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 115200,
    parameter int DUMP_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        dump_en_i,
    output logic        rib_rreq_o,
    output logic        mem_ren_o,
    output logic [31:0] mem_raddr_o,
    input  logic [31:0] mem_rdata_i,
    output logic        uart_tx,
    output logic        busy_o,
    output logic        done_o
);
    localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
    localparam int BW = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CNT - 1);
    localparam logic [15:0] LAST_WORD = 16'(DUMP_WORDS - 1);
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_RD    = 4'd1;
    localparam logic [3:0] S_WAIT  = 4'd2;
    localparam logic [3:0] S_LOAD  = 4'd3;
    localparam logic [3:0] S_START = 4'd4;
    localparam logic [3:0] S_DATA  = 4'd5;
    localparam logic [3:0] S_STOP  = 4'd6;
    localparam logic [3:0] S_DONE  = 4'd7;
`ifdef UART_DUMP_PARITY_EN
    localparam logic [3:0] S_PAR   = 4'd8;
    localparam logic [3:0] S_AFTER = S_PAR;
`else
    localparam logic [3:0] S_AFTER = S_STOP;
`endif

    logic          r_en_m;
    logic          r_en_s;
    logic          r_en_d;
    logic [3:0]    r_state;
    logic [3:0]    w_next;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nxt;
    logic [1:0]    r_byte;
    logic [15:0]   r_word;
    logic [31:0]   r_shift;
    logic          r_tx;
    logic          w_tx_nxt;
    logic          w_busy;
    logic          w_abort;
    logic          w_enter;
    logic          w_timed;
    logic          w_wrap;

    assign w_busy  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_abort = w_busy && !r_en_s;
    assign w_enter = (w_next != r_state);
    assign w_wrap  = (r_baud == BAUD_LAST);
`ifdef UART_DUMP_PARITY_EN
    assign w_timed = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP) || (r_state == S_PAR);
`else
    assign w_timed = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
`endif

    // two-flop synchronizer for the async request plus a delayed copy for edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_en_m <= 1'b0;
            r_en_s <= 1'b0;
            r_en_d <= 1'b0;
        end else begin
            r_en_m <= dump_en_i;
            r_en_s <= r_en_m;
            r_en_d <= r_en_s;
        end
    end

    // next-state logic; a dropped request in any busy state wins over everything
    always_comb begin
        w_next = r_state;
        if (w_abort) w_next = S_IDLE;
        else begin
            case (r_state)
                S_IDLE:  w_next = (r_en_s && !r_en_d) ? S_RD : S_IDLE;
                S_RD:    w_next = S_WAIT;
                S_WAIT:  w_next = S_LOAD;
                S_LOAD:  w_next = S_START;
                S_START: w_next = w_wrap ? S_DATA : S_START;
                S_DATA:  w_next = (w_wrap && r_bit == 3'd7) ? S_AFTER : S_DATA;
`ifdef UART_DUMP_PARITY_EN
                S_PAR:   w_next = w_wrap ? S_STOP : S_PAR;
`endif
                S_STOP:  w_next = !w_wrap ? S_STOP : (r_byte != 2'd3) ? S_START : (r_word != LAST_WORD) ? S_RD : S_DONE;
                S_DONE:  w_next = r_en_s ? S_DONE : S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    // bit-period counter: restarts on every state entry and at each bit boundary
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_baud <= '0;
        else r_baud <= (w_enter || w_wrap || !w_timed) ? '0 : r_baud + 1'b1;
    end

    // data bit index within the current byte
    assign w_bit_nxt = (r_state == S_DATA && w_next == S_DATA) ? (w_wrap ? r_bit + 3'd1 : r_bit) : 3'd0;

    // bit counter register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_bit <= 3'd0;
        else r_bit <= w_bit_nxt;
    end

    // byte and word counters; both drop to zero whenever the FSM heads to IDLE
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_byte <= 2'd0;
            r_word <= 16'd0;
        end else if (w_next == S_IDLE) begin
            r_byte <= 2'd0;
            r_word <= 16'd0;
        end else begin
            if (r_state == S_LOAD) r_byte <= 2'd0;
            else if (r_state == S_STOP && w_next == S_START) r_byte <= r_byte + 2'd1;
            if (r_state == S_STOP && w_next == S_RD) r_word <= r_word + 16'd1;
        end
    end

    // word shift register: captures read data in the cycle it is valid, then moves down a byte per frame
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_shift <= 32'd0;
        else if (w_next == S_IDLE) r_shift <= 32'd0;
        else if (r_state == S_WAIT) r_shift <= mem_rdata_i;
        else if (r_state == S_STOP && w_next == S_START) r_shift <= {8'd0, r_shift[31:8]};
    end

    // line level for the state being entered, so the serial output is glitch-free
    always_comb begin
        w_tx_nxt = 1'b1;
        if (w_next == S_START) w_tx_nxt = 1'b0;
        else if (w_next == S_DATA) w_tx_nxt = r_shift[w_bit_nxt];
`ifdef UART_DUMP_PARITY_EN
        else if (w_next == S_PAR) w_tx_nxt = ^r_shift[7:0];
`endif
    end

    // registered serial output, idle high
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_tx <= 1'b1;
        else r_tx <= w_tx_nxt;
    end

    assign uart_tx     = r_tx;
    assign busy_o      = w_busy;
    assign rib_rreq_o  = w_busy;
    assign done_o      = (r_state == S_DONE);
    assign mem_ren_o   = (r_state == S_RD);
    assign mem_raddr_o = {14'd0, r_word, 2'b00};
endmodule

// File: tb/tb_uart_dump_tx.sv
// tb_uart_dump_tx: directed bench for uart_dump_tx (BAUD_CNT=10, DUMP_WORDS=2); honours UART_DUMP_PARITY_EN.
module tb_uart_dump_tx;
`ifdef UART_DUMP_PARITY_EN
    localparam int FRAME = 110;
`else
    localparam int FRAME = 100;
`endif
    localparam int TMO = 3000;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        dump_en_i = 1'b0;
    logic        rib_rreq_o;
    logic        mem_ren_o;
    logic [31:0] mem_raddr_o;
    logic [31:0] mem_rdata_i;
    logic        uart_tx;
    logic        busy_o;
    logic        done_o;
    logic [31:0] mem [2];
    logic [31:0] rd_addr [16];
    int          rd_n = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp1 [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hFF, 8'h00, 8'hA5, 8'hA5};
    logic [7:0]  exp3 [8] = '{8'h07, 8'h03, 8'h00, 8'h80, 8'hF0, 8'h0F, 8'h3C, 8'hC3};
    logic [7:0]  b;
    int          t [8];
    int          t0;

    uart_dump_tx #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DUMP_WORDS(2)) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .dump_en_i(dump_en_i),
        .rib_rreq_o(rib_rreq_o),
        .mem_ren_o(mem_ren_o),
        .mem_raddr_o(mem_raddr_o),
        .mem_rdata_i(mem_rdata_i),
        .uart_tx(uart_tx),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(posedge clk_i) mem_rdata_i <= mem_ren_o ? mem[mem_raddr_o[2]] : 32'hDEAD_BEEF;
    always @(negedge clk_i) begin
        if (mem_ren_o && rd_n < 16) begin
            rd_addr[rd_n] = mem_raddr_o;
            rd_n = rd_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_start(output int ts);
        int n = 0;
        while (uart_tx !== 1'b0 && n < TMO) begin
            @(negedge clk_i);
            n++;
        end
        chk("start_timeout", 32'(n >= TMO), 32'd0);
        ts = cyc;
    endtask

    task automatic rx_byte(input string tag, output logic [7:0] rb, output int ts);
        logic s [FRAME];
        int glitch = 0;
        rb = '0;
        wait_start(ts);
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk_i);
            s[k] = uart_tx;
        end
        for (int k = 0; k < FRAME; k++) if (s[k] !== s[(k / 10) * 10 + 5]) glitch++;
        for (int j = 0; j < 8; j++) rb[j] = s[(j + 1) * 10 + 5];
        chk({tag, "_start"}, 32'(s[5]), 32'd0);
        chk({tag, "_width"}, 32'(glitch), 32'd0);
        chk({tag, "_stop"}, 32'(s[FRAME - 5]), 32'd1);
`ifdef UART_DUMP_PARITY_EN
        chk({tag, "_par"}, 32'(s[95]), 32'(^rb));
`endif
    endtask

    initial begin
        mem[0] = 32'h1234_5678;
        mem[1] = 32'hA5A5_00FF;
        #2 rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_rreq", 32'(rib_rreq_o), 32'd0);
        chk("rst_ren", 32'(mem_ren_o), 32'd0);
        chk("rst_raddr", mem_raddr_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        dump_en_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_byte($sformatf("d1_b%0d", i), b, t[i]);
            chk($sformatf("d1_byte%0d", i), 32'(b), 32'(exp1[i]));
        end
        chk("gap_byte", t[1] - t[0], FRAME);
        chk("gap_word", t[4] - t[3], FRAME + 3);
        @(negedge clk_i);
        chk("d1_done", 32'(done_o), 32'd1);
        chk("d1_busy", 32'(busy_o), 32'd0);
        chk("d1_rreq", 32'(rib_rreq_o), 32'd0);
        chk("d1_reads", rd_n, 32'd2);
        chk("d1_addr0", rd_addr[0], 32'h0);
        chk("d1_addr1", rd_addr[1], 32'h4);
        repeat (50) @(negedge clk_i);
        chk("hold_reads", rd_n, 32'd2);
        chk("hold_done", 32'(done_o), 32'd1);
        dump_en_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("idle_done", 32'(done_o), 32'd0);
        dump_en_i = 1'b1;
        rx_byte("d2_b0", b, t0);
        chk("d2_byte0", 32'(b), 32'h78);
        chk("d2_reads", rd_n, 32'd3);
        chk("d2_addr", rd_addr[2], 32'h0);
        wait_start(t0);
        repeat (45) @(negedge clk_i);
        dump_en_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("abort_pre_tx", 32'(uart_tx), 32'd0);
        chk("abort_pre_busy", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        chk("abort_tx", 32'(uart_tx), 32'd1);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_rreq", 32'(rib_rreq_o), 32'd0);
        repeat (100) @(negedge clk_i);
        chk("abort_reads", rd_n, 32'd3);
        chk("abort_idle_tx", 32'(uart_tx), 32'd1);
        dump_en_i = 1'b1;
        wait_start(t0);
        repeat (3) @(negedge clk_i);
        chk("mid_tx", 32'(uart_tx), 32'd0);
        rst_n_i = 1'b0;
        #1;
        chk("arst_tx", 32'(uart_tx), 32'd1);
        chk("arst_rreq", 32'(rib_rreq_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        dump_en_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        mem[0] = 32'h8000_0307;
        mem[1] = 32'hC33C_0FF0;
        repeat (2) @(negedge clk_i);
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        dump_en_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_byte($sformatf("d3_b%0d", i), b, t[i]);
            chk($sformatf("d3_byte%0d", i), 32'(b), 32'(exp3[i]));
        end
        @(negedge clk_i);
        chk("d3_done", 32'(done_o), 32'd1);
        chk("d3_reads", rd_n, 32'd6);
        chk("d3_addr1", rd_addr[5], 32'h4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
